ttt_network_router: RTL and testbench

- Parameterised successor to the TTT network multiplexer.
- On each `step` it snapshots every processor's start/stop event pair and scans sources sequentially. For every source with a net event it walks that source's programmed synapse range and accumulates signed, weighted good/bad token deltas into per-target accumulators.
- When the scan finishes it publishes all accumulators at once and pulses `enable` to the processor array.
- Connectivity (range table plus synapse table) is loaded through a simple write port while the router is idle.

---
 rtl/ttt_router_pkg.sv | 44 ++++
 rtl/ttt_router_acc_bank.sv | 65 ++++++
 rtl/ttt_network_router.sv | 167 ++++++++++++++++
 tb/tb_ttt_network_router.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_router_pkg.sv
// Shared types for the TTT network router: FSM states, table entry layouts
// and the saturating token arithmetic used by the accumulator bank.
package ttt_router_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SRC   = 3'd2,
        TGT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Table entries are unpacked into fixed-width fields so the types do not
    // depend on the router parameters; all instances use widths well below this.
    localparam int FIELD_BITS = 16;

    typedef struct packed {
        logic [FIELD_BITS-1:0] tgt_idx;
        logic                  bad;
        logic [FIELD_BITS-1:0] weight;
    } synapse_t;

    typedef struct packed {
        logic [FIELD_BITS-1:0] syn_start;
        logic [FIELD_BITS-1:0] syn_end;
    } range_t;

    function automatic int sat_add(input int acc, input int delta, input int bits);
        int lo;
        int hi;
        int sum;
        lo  = -(1 << (bits - 1));
        hi  = (1 << (bits - 1)) - 1;
        sum = acc + delta;
        if (sum > hi) begin
            sat_add = hi;
        end else if (sum < lo) begin
            sat_add = lo;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/ttt_router_acc_bank.sv
// Per-target good/bad token accumulators with clear, saturating indexed add
// and a one-shot copy to the published output registers.
module ttt_router_acc_bank
    import ttt_router_pkg::*;
#(
    parameter int N  = 10,
    parameter int TB = 4,
    parameter int IW = 4,
    parameter int FW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add_en,
    input  logic              add_bad,
    input  logic [IW-1:0]     add_idx,
    input  logic [FW-1:0]     add_delta,
    input  logic              publish,
    output logic [N*TB-1:0]   good_out,
    output logic [N*TB-1:0]   bad_out
);

    logic [TB-1:0] good_acc [N];
    logic [TB-1:0] bad_acc  [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                good_acc[i] <= '0;
                bad_acc[i]  <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                good_acc[i] <= '0;
                bad_acc[i]  <= '0;
            end
        end else if (add_en) begin
            // Indices at or beyond N match no entry, so such synapses are no-ops.
            for (int i = 0; i < N; i++) begin
                if (add_idx == IW'(i)) begin
                    if (add_bad) begin
                        bad_acc[i] <= TB'(sat_add(int'($signed(bad_acc[i])),
                                                  int'($signed(add_delta)), TB));
                    end else begin
                        good_acc[i] <= TB'(sat_add(int'($signed(good_acc[i])),
                                                   int'($signed(add_delta)), TB));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_out <= '0;
            bad_out  <= '0;
        end else if (publish) begin
            for (int i = 0; i < N; i++) begin
                good_out[i*TB +: TB] <= good_acc[i];
                bad_out[i*TB +: TB]  <= bad_acc[i];
            end
        end
    end

endmodule

// File: rtl/ttt_network_router.sv
// Event router: per step, scans every source's start/stop pair and accumulates
// signed, weighted token deltas into per-target good/bad outputs.
module ttt_network_router
    import ttt_router_pkg::*;
#(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int NUM_SYNAPSES    = 32,
    parameter int WEIGHT_BITS     = 3,
    localparam int IDX_BITS = $clog2(NUM_PROCESSORS),
    localparam int SYN_BITS = $clog2(NUM_SYNAPSES + 1),
    localparam int AW = (IDX_BITS > SYN_BITS) ? IDX_BITS : SYN_BITS,
    localparam int PW = (2*SYN_BITS > IDX_BITS+1+WEIGHT_BITS) ? 2*SYN_BITS
                                                              : IDX_BITS+1+WEIGHT_BITS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  step,
    input  logic [2*NUM_PROCESSORS-1:0]           tstartstop,
    input  logic                                  prog_we,
    input  logic                                  prog_sel,
    input  logic [AW-1:0]                         prog_addr,
    input  logic [PW-1:0]                         prog_data,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] new_good_tokens,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] new_bad_tokens,
    output logic                                  enable,
    output logic                                  busy,
    output logic [2:0]                            state_dbg
);

    localparam int SA_BITS = (NUM_SYNAPSES > 1) ? $clog2(NUM_SYNAPSES) : 1;
    localparam int RNG_W   = 2 * SYN_BITS;
    localparam int SYN_W   = IDX_BITS + 1 + WEIGHT_BITS;

    state_t                      state;
    logic [2*NUM_PROCESSORS-1:0] snap;
    logic [IDX_BITS-1:0]         src_idx;
    logic [SYN_BITS-1:0]         syn_ptr;
    logic [SYN_BITS-1:0]         cur_end;
    logic                        cur_neg;
    logic [RNG_W-1:0]            range_mem [NUM_PROCESSORS];
    logic [SYN_W-1:0]            syn_mem   [NUM_SYNAPSES];

    logic                  src_start;
    logic                  src_stop;
    logic                  last_src;
    logic                  syn_in_range;
    logic                  tgt_valid;
    logic                  tgt_last;
    logic [SYN_BITS-1:0]   ptr_next;
    logic [FIELD_BITS-1:0] delta;
    range_t                cur_rng;
    synapse_t              cur_syn;

    function automatic synapse_t unpack_syn(input logic [SYN_W-1:0] raw);
        synapse_t s;
        s.tgt_idx = FIELD_BITS'(raw[SYN_W-1 -: IDX_BITS]);
        s.bad     = raw[WEIGHT_BITS];
        s.weight  = {{(FIELD_BITS-WEIGHT_BITS){raw[WEIGHT_BITS-1]}}, raw[WEIGHT_BITS-1:0]};
        return s;
    endfunction

    always_comb begin
        src_start = 1'b0;
        src_stop  = 1'b0;
        for (int i = 0; i < NUM_PROCESSORS; i++) begin
            if (src_idx == IDX_BITS'(i)) begin
                src_start = snap[2*i+1];
                src_stop  = snap[2*i];
            end
        end
        cur_rng.syn_start = FIELD_BITS'(range_mem[src_idx][SYN_BITS-1:0]);
        cur_rng.syn_end   = FIELD_BITS'(range_mem[src_idx][RNG_W-1:SYN_BITS]);
        last_src     = (src_idx == IDX_BITS'(NUM_PROCESSORS - 1));
        syn_in_range = (syn_ptr < SYN_BITS'(NUM_SYNAPSES));
        cur_syn      = unpack_syn(syn_mem[syn_ptr[SA_BITS-1:0]]);
        tgt_valid    = syn_in_range && (cur_syn.tgt_idx < FIELD_BITS'(NUM_PROCESSORS));
        delta        = cur_neg ? (~cur_syn.weight + 1'b1) : cur_syn.weight;
        ptr_next     = syn_ptr + 1'b1;
        tgt_last     = (ptr_next == cur_end) || (ptr_next >= SYN_BITS'(NUM_SYNAPSES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            snap    <= '0;
            src_idx <= '0;
            syn_ptr <= '0;
            cur_end <= '0;
            cur_neg <= 1'b0;
            enable  <= 1'b0;
            for (int i = 0; i < NUM_PROCESSORS; i++) range_mem[i] <= '0;
            for (int i = 0; i < NUM_SYNAPSES; i++)   syn_mem[i]   <= '0;
        end else begin
            enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (prog_we) begin
                        if (!prog_sel && prog_addr < AW'(NUM_PROCESSORS))
                            range_mem[prog_addr[IDX_BITS-1:0]] <= prog_data[RNG_W-1:0];
                        if (prog_sel && prog_addr < AW'(NUM_SYNAPSES))
                            syn_mem[prog_addr[SA_BITS-1:0]] <= prog_data[SYN_W-1:0];
                    end
                    if (step) begin
                        snap  <= tstartstop;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    src_idx <= '0;
                    state   <= SRC;
                end
                SRC: begin
                    // start^stop is a non-zero sign; stop alone means negative.
                    if ((src_start ^ src_stop) && (cur_rng.syn_start < cur_rng.syn_end)) begin
                        syn_ptr <= SYN_BITS'(cur_rng.syn_start);
                        cur_end <= SYN_BITS'(cur_rng.syn_end);
                        cur_neg <= src_stop;
                        state   <= TGT;
                    end else if (last_src) begin
                        state <= DONE;
                    end else begin
                        src_idx <= src_idx + 1'b1;
                    end
                end
                TGT: begin
                    syn_ptr <= ptr_next;
                    if (tgt_last) begin
                        if (last_src) begin
                            state <= DONE;
                        end else begin
                            src_idx <= src_idx + 1'b1;
                            state   <= SRC;
                        end
                    end
                end
                DONE: begin
                    enable <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    ttt_router_acc_bank #(
        .N  (NUM_PROCESSORS),
        .TB (NEW_TOKENS_BITS),
        .IW (IDX_BITS),
        .FW (FIELD_BITS)
    ) u_acc_bank (
        .clk       (clk),
        .rst       (reset),
        .clear     (state == CLEAR),
        .add_en    ((state == TGT) && tgt_valid),
        .add_bad   (cur_syn.bad),
        .add_idx   (IDX_BITS'(cur_syn.tgt_idx)),
        .add_delta (delta),
        .publish   (state == DONE),
        .good_out  (new_good_tokens),
        .bad_out   (new_bad_tokens)
    );

endmodule

// File: tb/tb_ttt_network_router.sv
// Self-checking bench for ttt_network_router: a reference model computes
// expected tokens and latency per pass, queued and compared at each enable.
module tb_ttt_network_router;
  localparam int N  = 10;
  localparam int TB = 4;
  localparam int NS = 32;
  localparam int AW = 6;
  localparam int PW = 12;
  localparam int EW = 16 + 2*N*TB;

  logic            clk = 1'b0;
  logic            reset;
  logic            step;
  logic [2*N-1:0]  tstartstop;
  logic            prog_we;
  logic            prog_sel;
  logic [AW-1:0]   prog_addr;
  logic [PW-1:0]   prog_data;
  logic [N*TB-1:0] new_good_tokens;
  logic [N*TB-1:0] new_bad_tokens;
  logic            enable;
  logic            busy;
  logic [2:0]      state_dbg;

  int total_checks = 0;
  int bad_checks   = 0;
  logic [EW-1:0] exp_q[$];

  int m_rs[N];
  int m_re[N];
  int m_tgt[NS];
  int m_bad[NS];
  int m_w[NS];

  ttt_network_router dut (
    .clk(clk), .reset(reset), .step(step), .tstartstop(tstartstop),
    .prog_we(prog_we), .prog_sel(prog_sel), .prog_addr(prog_addr), .prog_data(prog_data),
    .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens),
    .enable(enable), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_rs[i] = 0;
      m_re[i] = 0;
    end
    for (int p = 0; p < NS; p++) begin
      m_tgt[p] = 0;
      m_bad[p] = 0;
      m_w[p]   = 0;
    end
  endtask

  function automatic int clamp(input int x);
    if (x > 7) return 7;
    if (x < -8) return -8;
    return x;
  endfunction

  function automatic logic [EW-1:0] model_pass(input logic [2*N-1:0] tss);
    int g[N];
    int b[N];
    int lat;
    int sgn;
    int t;
    logic [EW-1:0] r;
    for (int i = 0; i < N; i++) begin
      g[i] = 0;
      b[i] = 0;
    end
    lat = N + 2;
    for (int s = 0; s < N; s++) begin
      sgn = int'(tss[2*s+1]) - int'(tss[2*s]);
      if (sgn != 0 && m_rs[s] < m_re[s]) begin
        for (int p = m_rs[s]; p < m_re[s] && p < NS; p++) begin
          lat++;
          t = m_tgt[p];
          if (t < N) begin
            if (m_bad[p] != 0) b[t] = clamp(b[t] + sgn * m_w[p]);
            else               g[t] = clamp(g[t] + sgn * m_w[p]);
          end
        end
      end
    end
    r = '0;
    r[EW-1 -: 16] = 16'(lat);
    for (int i = 0; i < N; i++) begin
      r[N*TB + i*TB +: TB] = TB'(g[i]);
      r[i*TB +: TB]        = TB'(b[i]);
    end
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step = 1'b0;
    prog_we = 1'b0;
    prog_sel = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    tstartstop = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic prog_range(input int src, input int st, input int en);
    @(negedge clk);
    prog_we = 1'b1;
    prog_sel = 1'b0;
    prog_addr = AW'(src);
    prog_data = {6'(en), 6'(st)};
    @(posedge clk);
    #1 prog_we = 1'b0;
    if (src < N) begin
      m_rs[src] = st;
      m_re[src] = en;
    end
  endtask

  task automatic prog_syn(input int idx, input int tgt, input int bad, input int w);
    @(negedge clk);
    prog_we = 1'b1;
    prog_sel = 1'b1;
    prog_addr = AW'(idx);
    prog_data = PW'({4'(tgt), 1'(bad), 3'(w)});
    @(posedge clk);
    #1 prog_we = 1'b0;
    if (idx < NS) begin
      m_tgt[idx] = tgt & 15;
      m_bad[idx] = bad;
      m_w[idx]   = w;
    end
  endtask

  task automatic run_pass(input logic [2*N-1:0] tss, input bit inject);
    int cycles;
    bit seen;
    logic [EW-1:0] e;
    exp_q.push_back(model_pass(tss));
    @(negedge clk);
    tstartstop = tss;
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    check("busy_on_accept", 64'(busy), 64'd1);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 300) begin
      @(posedge clk);
      #1 cycles++;
      if (inject) begin
        if (cycles <= 3) begin
          step = 1'b1;
          prog_we = 1'b1;
          prog_sel = 1'b0;
          prog_addr = AW'(5);
          prog_data = {6'd2, 6'd0};
          tstartstop = ~tss;
        end else begin
          step = 1'b0;
          prog_we = 1'b0;
        end
      end
      if (enable) seen = 1'b1;
    end
    step = 1'b0;
    prog_we = 1'b0;
    e = exp_q.pop_front();
    check("enable_seen", 64'(seen), 64'd1);
    check("latency", 64'(cycles), 64'(e[EW-1 -: 16]));
    check("good_tokens", 64'(new_good_tokens), 64'(e[2*N*TB-1 -: N*TB]));
    check("bad_tokens", 64'(new_bad_tokens), 64'(e[N*TB-1:0]));
    check("idle_at_enable", 64'(busy), 64'd0);
  endtask

  task automatic no_enable_for(input int n, input string tag);
    int extra;
    extra = 0;
    repeat (n) begin
      @(posedge clk);
      #1 if (enable) extra++;
    end
    check(tag, 64'(extra), 64'd0);
  endtask

  initial begin
    logic [2*N-1:0] t;
    int k;
    int st;
    int en;

    do_reset();
    #1;
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_good", 64'(new_good_tokens), 64'd0);
    check("rst_bad", 64'(new_bad_tokens), 64'd0);

    // Empty tables, no events: bare scan latency.
    run_pass('0, 1'b0);

    prog_range(0, 0, 2);
    prog_syn(0, 3, 0, 2);
    prog_syn(1, 5, 1, 1);
    t = '0; t[1] = 1'b1;
    run_pass(t, 1'b0);
    t = '0; t[0] = 1'b1;
    run_pass(t, 1'b0);
    t = '0; t[1] = 1'b1; t[0] = 1'b1;
    run_pass(t, 1'b0);

    // Four sources sharing one +3 synapse to target 1: saturation both ways.
    prog_syn(4, 1, 0, 3);
    for (int s = 0; s < 4; s++) prog_range(s, 4, 5);
    t = 20'h000AA;
    run_pass(t, 1'b0);
    t = 20'h00055;
    run_pass(t, 1'b0);

    // Step, table write and input changes while busy are all ignored.
    t = 20'h000AA;
    run_pass(t, 1'b1);
    no_enable_for(20, "no_queued_step");
    t = '0; t[11] = 1'b1;
    run_pass(t, 1'b0);

    // Empty range on source 6; out-of-range target on source 7.
    prog_range(6, 2, 2);
    prog_syn(5, 12, 0, 3);
    prog_range(7, 5, 6);
    t = '0; t[13] = 1'b1; t[15] = 1'b1;
    run_pass(t, 1'b0);

    // Leave non-zero outputs, then reset in the middle of a pass.
    t = 20'h00055;
    run_pass(t, 1'b0);
    @(negedge clk);
    tstartstop = 20'h000AA;
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    k = 0;
    while (state_dbg != 3'd3 && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    check("reached_tgt", 64'(state_dbg), 64'd3);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_enable", 64'(enable), 64'd0);
    check("midrst_good", 64'(new_good_tokens), 64'd0);
    check("midrst_bad", 64'(new_bad_tokens), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    no_enable_for(30, "no_enable_after_reset");
    t = 20'hAAAAA;
    run_pass(t, 1'b0);

    // Random connectivity and event patterns.
    for (int it = 0; it < 4; it++) begin
      for (int s = 0; s < N; s++) begin
        st = int'($urandom_range(0, 31));
        en = st + int'($urandom_range(0, 3));
        if (en > NS) en = NS;
        prog_range(s, st, en);
      end
      for (int p = 0; p < NS; p++)
        prog_syn(p, int'($urandom_range(0, 11)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)) - 4);
      t = 20'($urandom);
      run_pass(t, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
